// File: rtl/shift_reg_sequencer.sv
// Command sequencer for an external universal shift register: it loads, shifts or
// rotates the register a requested number of steps and returns the final contents.
module shift_reg_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic             cmd_fill,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             abort,
    output logic [1:0]       sel,
    output logic             serial_in,
    output logic [WIDTH-1:0] parallel_in,
    input  logic [WIDTH-1:0] q,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_SHL   = 2'b10;
    localparam logic [1:0] OP_ROR   = 2'b11;

    localparam logic [1:0] SEL_HOLD  = 2'b00;
    localparam logic [1:0] SEL_RIGHT = 2'b01;
    localparam logic [1:0] SEL_LEFT  = 2'b10;
    localparam logic [1:0] SEL_LOAD  = 2'b11;

    state_t             state, state_next;
    logic [1:0]         op_q;
    logic               fill_q;
    logic [WIDTH-1:0]   data_q;
    logic [CNT_W-1:0]   remaining;
    logic               accept;

    assign accept = cmd_valid && cmd_ready;

    // NOTE: state and command registers use non-blocking assignments so every
    // flop samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= OP_LOAD;
            fill_q    <= 1'b0;
            data_q    <= '0;
            remaining <= '0;
        end else if (accept) begin
            op_q      <= cmd_op;
            fill_q    <= cmd_fill;
            data_q    <= cmd_data;
            remaining <= cmd_cnt;
        end else if (state == SHIFT) begin
            remaining <= remaining - CNT_W'(1);
        end
    end

    // NOTE: the default assignment up front keeps every path assigned, so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (cmd_op == OP_LOAD)       state_next = LOAD;
                    else if (cmd_cnt == '0)      state_next = DONE;
                    else                         state_next = SHIFT;
                end
            end
            LOAD:  state_next = abort ? IDLE : DONE;
            SHIFT: begin
                if (abort)                            state_next = IDLE;
                else if (remaining == CNT_W'(1))      state_next = DONE;
            end
            DONE:  if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decode from the registered state only, so reset drops sel to hold at once.
    always_comb begin
        cmd_ready = 1'b0;
        sel       = SEL_HOLD;
        serial_in = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            LOAD: sel = SEL_LOAD;
            SHIFT: begin
                sel       = (op_q == OP_SHL) ? SEL_LEFT : SEL_RIGHT;
                serial_in = (op_q == OP_ROR) ? q[0] : fill_q;
            end
            DONE: rsp_valid = 1'b1;
            default: ;
        endcase
    end

    assign parallel_in = data_q;
    assign rsp_data    = q;

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Scoreboard bench: a behavioural universal shift register closes the loop around
// the sequencer; directed commands push expected results, a monitor checks responses.
module tb_shift_reg_sequencer;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'b00;
    logic [CNT_W-1:0] cmd_cnt = '0;
    logic             cmd_fill = 1'b0;
    logic [WIDTH-1:0] cmd_data = '0;
    logic             abort = 1'b0;
    logic [1:0]       sel;
    logic             serial_in;
    logic [WIDTH-1:0] parallel_in;
    logic [WIDTH-1:0] q = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [WIDTH-1:0] rsp_data;
    logic             busy;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               due;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;

    shift_reg_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .cmd_fill(cmd_fill), .cmd_data(cmd_data),
        .abort(abort),
        .sel(sel), .serial_in(serial_in), .parallel_in(parallel_in), .q(q),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Universal shift register driven by the sequencer (not reset by rst).
    always @(posedge clk) begin
        case (sel)
            2'b01: q <= {serial_in, q[WIDTH-1:1]};
            2'b10: q <= {q[WIDTH-2:0], serial_in};
            2'b11: q <= parallel_in;
            default: q <= q;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: samples just after the falling edge, when inputs for the next edge are settled.
    logic prev_valid = 1'b0;
    int   first_cyc = 0;
    always @(negedge clk) begin
        #1;
        if (rsp_valid && !prev_valid) first_cyc = cyc;
        prev_valid = rsp_valid;
        if (rsp_valid && rsp_ready) begin
            check("rsp_expected", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_data", rsp_data, e.data);
                check("rsp_latency", first_cyc, e.due);
            end
        end
    end

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle"}, busy, 0);
    endtask

    task automatic drive_cmd(input logic [1:0] op, input logic [2:0] cnt, input logic fill,
                             input logic [3:0] data);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_cnt   = cnt;
        cmd_fill  = fill;
        cmd_data  = data;
    endtask

    // Issues one command at a falling edge while idle, checks the sel pattern and completion.
    task automatic do_cmd(input string tag, input logic [1:0] op, input logic [2:0] cnt,
                          input logic fill, input logic [3:0] data, input logic [3:0] exp_data,
                          input int lat, input logic [1:0] exp_sel, input int n_sel);
        exp_t e;
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        check({tag, "_idle_sel"}, sel, 2'b00);
        drive_cmd(op, cnt, fill, data);
        e.data = exp_data;
        e.due  = cyc + lat;
        sb.push_back(e);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < n_sel; i++) begin
            check({tag, "_sel"}, sel, exp_sel);
            check({tag, "_busy"}, busy, 1);
            @(negedge clk);
        end
        check({tag, "_done_sel"}, sel, 2'b00);
        check({tag, "_done_valid"}, rsp_valid, 1);
        wait_idle(tag);
    endtask

    initial begin
        #3;
        check("rst_sel", sel, 2'b00);
        check("rst_serial_in", serial_in, 0);
        check("rst_parallel_in", parallel_in, 4'b0000);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_data", rsp_data, q);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Load, shift right, shift left, rotate, zero-count rotate, back to back.
        do_cmd("load",  2'b00, 3'd0, 1'b0, 4'b1100, 4'b1100, 2, 2'b11, 1);
        do_cmd("shr",   2'b01, 3'd2, 1'b1, 4'b0000, 4'b1111, 3, 2'b01, 2);
        do_cmd("shl",   2'b10, 3'd3, 1'b0, 4'b0000, 4'b1000, 4, 2'b10, 3);
        do_cmd("ror",   2'b11, 3'd3, 1'b0, 4'b0000, 4'b0001, 4, 2'b01, 3);
        do_cmd("ror0",  2'b11, 3'd0, 1'b0, 4'b0000, 4'b0001, 1, 2'b00, 0);

        // Response held off for 5 cycles in DONE.
        begin
            exp_t e;
            rsp_ready = 1'b0;
            drive_cmd(2'b00, 3'd0, 1'b0, 4'b1010);
            e.data = 4'b1010;
            e.due  = cyc + 2;
            sb.push_back(e);
            @(negedge clk);
            cmd_valid = 1'b0;
            @(negedge clk);
            for (int i = 0; i < 5; i++) begin
                check("hold_valid", rsp_valid, 1);
                check("hold_data", rsp_data, 4'b1010);
                check("hold_cmd_ready", cmd_ready, 0);
                check("hold_sel", sel, 2'b00);
                @(negedge clk);
            end
            rsp_ready = 1'b1;
            wait_idle("hold");
        end

        // Abort on the third SHIFT cycle of a 7-step shift right.
        do_cmd("ld0a", 2'b00, 3'd0, 1'b0, 4'b0000, 4'b0000, 2, 2'b11, 1);
        drive_cmd(2'b01, 3'd7, 1'b1, 4'b0000);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("abort_sel1", sel, 2'b01);
        @(negedge clk);
        check("abort_sel2", sel, 2'b01);
        @(negedge clk);
        check("abort_sel3", sel, 2'b01);
        check("abort_serial", serial_in, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_cmd_ready", cmd_ready, 1);
        check("abort_rsp_valid", rsp_valid, 0);
        check("abort_q", q, 4'b1110);
        @(negedge clk);
        check("abort_q_hold", q, 4'b1110);
        check("abort_sel_after", sel, 2'b00);

        // Asynchronous reset during the third SHIFT cycle.
        do_cmd("ld0r", 2'b00, 3'd0, 1'b0, 4'b0000, 4'b0000, 2, 2'b11, 1);
        drive_cmd(2'b01, 3'd7, 1'b1, 4'b0000);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rstm_sel_before", sel, 2'b01);
        rst = 1'b1;
        #1;
        check("rstm_sel", sel, 2'b00);
        check("rstm_serial_in", serial_in, 0);
        check("rstm_parallel_in", parallel_in, 4'b0000);
        check("rstm_busy", busy, 0);
        check("rstm_cmd_ready", cmd_ready, 1);
        check("rstm_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        check("rstm_q", q, 4'b1100);
        rst = 1'b0;
        @(negedge clk);
        check("rstm_q_hold", q, 4'b1100);

        do_cmd("recover", 2'b00, 3'd0, 1'b0, 4'b0110, 4'b0110, 2, 2'b11, 1);
        do_cmd("shl1",    2'b10, 3'd1, 1'b1, 4'b0000, 4'b1101, 2, 2'b10, 1);

        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
